// File: rtl/fx_chain_ctrl.sv
// rtl/fx_chain_ctrl.sv - effect chain sequencer with debounced footswitch and gain controls
module fx_chain_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DB_W            = 16,
    parameter int MAX_GAIN        = 4,
    parameter int TIMEOUT         = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_tick,
    input  logic [11:0] adc_data,
    input  logic        sw_dist,
    input  logic        sw_rev,
    input  logic        btn_gain_up,
    input  logic        btn_gain_dn,
    input  logic        err_clr,
    output logic [11:0] dist_A,
    output logic        dist_valid_in,
    input  logic [11:0] dist_S,
    input  logic        dist_valid_out,
    output logic        dist_toggle_en,
    output logic [11:0] gain_factor,
    output logic [11:0] rev_in,
    output logic        rev_update,
    input  logic [11:0] rev_out,
    input  logic        rev_valid_out,
    output logic        rev_toggle_en,
    output logic [11:0] dac_data,
    output logic        dac_valid,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, DIST, REV, OUT} state_t;

    localparam int               WW        = $clog2(TIMEOUT + 1);
    localparam logic [DB_W-1:0]  DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [WW-1:0]    WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [11:0]      GAIN_MAX  = 12'(MAX_GAIN);

    state_t          state;
    logic [WW-1:0]   wait_cnt;
    logic [3:0]      raw, sync1, sync2, sync3, db_lvl, rise, pend;
    logic [DB_W-1:0] db_cnt [4];
    logic            apply, to_evt;

    // Bit order for all control vectors: 0 dist, 1 rev, 2 gain up, 3 gain down.
    assign raw   = {btn_gain_dn, btn_gain_up, sw_rev, sw_dist};
    assign busy  = (state != IDLE);
    assign apply = (state == IDLE) && !sample_tick;

    always_comb begin
        rise = '0;
        for (int i = 0; i < 4; i++)
            rise[i] = (sync2[i] == sync3[i]) && (db_cnt[i] == DB_MAX) && sync3[i] && !db_lvl[i];
    end

    always_comb begin
        to_evt = 1'b0;
        if (wait_cnt == WAIT_LAST)
            to_evt = ((state == DIST) && !dist_valid_out) || ((state == REV) && !rev_valid_out);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            sync3  <= '0;
            db_lvl <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != sync3[i]) begin
                    sync3[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] != DB_MAX) begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end else begin
                    db_lvl[i] <= sync3[i];
                end
            end
        end
    end

    // Pending controls are only consumed between samples; an edge landing on the apply cycle is kept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend           <= '0;
            dist_toggle_en <= 1'b0;
            rev_toggle_en  <= 1'b0;
            gain_factor    <= '0;
        end else begin
            dist_toggle_en <= apply && pend[0];
            if (apply) begin
                pend <= rise;
                if (pend[1])
                    rev_toggle_en <= ~rev_toggle_en;
                if (pend[2] && !pend[3] && gain_factor < GAIN_MAX)
                    gain_factor <= gain_factor + 12'd1;
                else if (pend[3] && !pend[2] && gain_factor != 12'd0)
                    gain_factor <= gain_factor - 12'd1;
            end else begin
                pend <= pend | rise;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            dist_A        <= '0;
            dist_valid_in <= 1'b0;
            rev_in        <= '0;
            rev_update    <= 1'b0;
            dac_data      <= '0;
            dac_valid     <= 1'b0;
            overrun       <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            dist_valid_in <= 1'b0;
            rev_update    <= 1'b0;
            dac_valid     <= 1'b0;
            overrun       <= (overrun && !err_clr) || (sample_tick && busy);
            timeout_err   <= (timeout_err && !err_clr) || to_evt;
            case (state)
                IDLE: if (sample_tick) begin
                    dist_A        <= adc_data;
                    dist_valid_in <= 1'b1;
                    wait_cnt      <= '0;
                    state         <= DIST;
                end
                DIST: if (dist_valid_out) begin
                    rev_in     <= dist_S;
                    rev_update <= 1'b1;
                    wait_cnt   <= '0;
                    state      <= REV;
                end else if (to_evt) begin
                    state <= IDLE;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                REV: if (rev_valid_out) begin
                    dac_data  <= rev_out;
                    dac_valid <= 1'b1;
                    state     <= OUT;
                end else if (to_evt) begin
                    state <= IDLE;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                OUT:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fx_chain_ctrl.sv
// tb/tb_fx_chain_ctrl.sv - directed, table-driven bench for fx_chain_ctrl
module tb_fx_chain_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_tick = 1'b0;
    logic [11:0] adc_data = '0;
    logic        sw_dist = 1'b0, sw_rev = 1'b0, btn_gain_up = 1'b0, btn_gain_dn = 1'b0;
    logic        err_clr = 1'b0;
    logic [11:0] dist_A, gain_factor, rev_in, dac_data;
    logic        dist_valid_in, dist_toggle_en, rev_update, rev_toggle_en;
    logic        dac_valid, busy, overrun, timeout_err;
    logic [11:0] dist_S = '0, rev_out = '0;
    logic        dist_valid_out = 1'b0, rev_valid_out = 1'b0;
    logic        rev_silent = 1'b0, rev_kick = 1'b0;

    int checks = 0;
    int errors = 0;
    int pulses, early, first_off, busy_at_pulse, dv;

    typedef struct {
        logic [11:0] adc;
        logic [11:0] e_rev;
        logic [11:0] e_dac;
    } svec_t;

    typedef struct {
        logic        up;
        logic        dn;
        logic [11:0] e_gain;
    } gvec_t;

    svec_t stab[5];
    gvec_t gtab[13];

    fx_chain_ctrl #(.DEBOUNCE_CYCLES(4), .DB_W(4), .MAX_GAIN(4), .TIMEOUT(6)) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .adc_data(adc_data),
        .sw_dist(sw_dist), .sw_rev(sw_rev), .btn_gain_up(btn_gain_up), .btn_gain_dn(btn_gain_dn),
        .err_clr(err_clr), .dist_A(dist_A), .dist_valid_in(dist_valid_in), .dist_S(dist_S),
        .dist_valid_out(dist_valid_out), .dist_toggle_en(dist_toggle_en), .gain_factor(gain_factor),
        .rev_in(rev_in), .rev_update(rev_update), .rev_out(rev_out), .rev_valid_out(rev_valid_out),
        .rev_toggle_en(rev_toggle_en), .dac_data(dac_data), .dac_valid(dac_valid), .busy(busy),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // One-cycle echo stages: clip adds 1, reverb adds 2.
    always @(posedge clk) begin
        dist_valid_out <= dist_valid_in;
        dist_S         <= dist_A + 12'd1;
        rev_valid_out  <= (rev_update && !rev_silent) || rev_kick;
        if (rev_update) rev_out <= rev_in + 12'd2;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_sample(input logic [11:0] adc, input logic [11:0] e_rev, input logic [11:0] e_dac);
        adc_data    = adc;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check("smp_dist_valid_in", dist_valid_in, 1);
        check("smp_dist_A", dist_A, adc);
        step();
        check("smp_dist_valid_in_once", dist_valid_in, 0);
        step();
        check("smp_rev_update", rev_update, 1);
        check("smp_rev_in", rev_in, e_rev);
        step();
        step();
        check("smp_dac_valid", dac_valid, 1);
        check("smp_dac_data", dac_data, e_dac);
        check("smp_busy_out", busy, 1);
        step();
        check("smp_busy_done", busy, 0);
        check("smp_dac_valid_once", dac_valid, 0);
    endtask

    task automatic press(input logic up, input logic dn);
        btn_gain_up = up;
        btn_gain_dn = dn;
        repeat (12) step();
        btn_gain_up = 1'b0;
        btn_gain_dn = 1'b0;
        repeat (12) step();
    endtask

    initial begin
        stab[0] = '{12'h100, 12'h101, 12'h103};
        stab[1] = '{12'h000, 12'h001, 12'h003};
        stab[2] = '{12'hFFC, 12'hFFD, 12'hFFF};
        stab[3] = '{12'hFFE, 12'hFFF, 12'h001};
        stab[4] = '{12'hA5A, 12'hA5B, 12'hA5D};
        gtab[0]  = '{1'b1, 1'b0, 12'd1};
        gtab[1]  = '{1'b1, 1'b0, 12'd2};
        gtab[2]  = '{1'b1, 1'b0, 12'd3};
        gtab[3]  = '{1'b1, 1'b0, 12'd4};
        gtab[4]  = '{1'b1, 1'b0, 12'd4};
        gtab[5]  = '{1'b1, 1'b0, 12'd4};
        gtab[6]  = '{1'b0, 1'b1, 12'd3};
        gtab[7]  = '{1'b0, 1'b1, 12'd2};
        gtab[8]  = '{1'b0, 1'b1, 12'd1};
        gtab[9]  = '{1'b0, 1'b1, 12'd0};
        gtab[10] = '{1'b0, 1'b1, 12'd0};
        gtab[11] = '{1'b1, 1'b0, 12'd1};
        gtab[12] = '{1'b1, 1'b1, 12'd1};

        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_dac_valid", dac_valid, 0);
        check("rst_dac_data", dac_data, 0);
        check("rst_gain", gain_factor, 0);
        check("rst_rev_toggle_en", rev_toggle_en, 0);
        check("rst_dist_toggle_en", dist_toggle_en, 0);
        check("rst_flags", {overrun, timeout_err}, 0);
        reset = 1'b0;
        repeat (8) step();

        for (int i = 0; i < 5; i++) run_sample(stab[i].adc, stab[i].e_rev, stab[i].e_dac);

        for (int i = 0; i < 13; i++) begin
            press(gtab[i].up, gtab[i].dn);
            check("gain_table", gain_factor, gtab[i].e_gain);
        end

        // Bouncing footswitch then a steady press: exactly one late toggle pulse.
        early = 0;
        for (int i = 0; i < 10; i++) begin
            sw_dist = (i % 2 == 0);
            step();
            if (dist_toggle_en) early++;
            step();
            if (dist_toggle_en) early++;
        end
        sw_dist = 1'b1;
        pulses = 0;
        first_off = -1;
        busy_at_pulse = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (dist_toggle_en) begin
                pulses++;
                if (first_off < 0) first_off = k;
                if (busy) busy_at_pulse = 1;
            end
        end
        check("bounce_no_early_pulse", early, 0);
        check("bounce_one_pulse", pulses, 1);
        check("bounce_delay_ge6", first_off >= 6, 1);
        check("bounce_pulse_idle", busy_at_pulse, 0);
        sw_dist = 1'b0;
        repeat (12) step();

        // Reverb switch debounces while the sample sits in REV.
        rev_silent  = 1'b1;
        adc_data    = 12'h050;
        sample_tick = 1'b1;
        sw_rev      = 1'b1;
        step();
        sample_tick = 1'b0;
        repeat (5) step();
        check("defer_busy_in_rev", busy, 1);
        check("defer_rte_hold0", rev_toggle_en, 0);
        step();
        rev_kick = 1'b1;
        step();
        rev_kick = 1'b0;
        check("defer_rte_hold1", rev_toggle_en, 0);
        step();
        check("defer_dac_valid", dac_valid, 1);
        check("defer_dac_data", dac_data, 12'h053);
        check("defer_rte_hold2", rev_toggle_en, 0);
        check("defer_no_timeout", timeout_err, 0);
        step();
        check("defer_idle", busy, 0);
        check("defer_rte_hold3", rev_toggle_en, 0);
        step();
        check("defer_rte_applied", rev_toggle_en, 1);
        rev_silent = 1'b0;
        sw_rev     = 1'b0;
        repeat (12) step();

        // Overrun: second tick two cycles after the first.
        adc_data    = 12'h200;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        check("ovr_clear_before", overrun, 0);
        adc_data    = 12'h2AA;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check("ovr_set", overrun, 1);
        check("ovr_rev_in", rev_in, 12'h201);
        dv = 0;
        for (int k = 0; k < 10; k++) begin
            if (dac_valid) dv++;
            step();
        end
        check("ovr_one_dac_valid", dv, 1);
        check("ovr_dac_data", dac_data, 12'h203);
        check("ovr_sticky", overrun, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("ovr_cleared", overrun, 0);

        // err_clr coinciding with a new overrun: the set wins.
        adc_data    = 12'h300;
        sample_tick = 1'b1;
        step();
        err_clr = 1'b1;
        step();
        sample_tick = 1'b0;
        err_clr     = 1'b0;
        check("ovr_set_wins", overrun, 1);
        repeat (8) step();

        // Silent reverb: timeout six cycles after REV entry, sample dropped.
        rev_silent  = 1'b1;
        adc_data    = 12'h3F0;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        step();
        check("to_rev_entry", rev_update, 1);
        dv = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (dac_valid) dv++;
        end
        check("to_not_yet", timeout_err, 0);
        check("to_still_busy", busy, 1);
        step();
        if (dac_valid) dv++;
        check("to_set", timeout_err, 1);
        check("to_idle", busy, 0);
        step();
        if (dac_valid) dv++;
        check("to_no_dac_valid", dv, 0);
        check("to_dac_data_kept", dac_data, 12'h303);
        rev_silent = 1'b0;
        err_clr    = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_flags", {overrun, timeout_err}, 0);

        // Stray reverb valid while idle.
        rev_kick = 1'b1;
        step();
        rev_kick = 1'b0;
        step();
        step();
        check("stray_busy", busy, 0);
        check("stray_dac_valid", dac_valid, 0);
        check("stray_dac_data", dac_data, 12'h303);

        // Reset while the sample is in DIST.
        adc_data    = 12'h123;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check("mid_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_dvi", dist_valid_in, 0);
        check("mid_rst_dist_A", dist_A, 0);
        check("mid_rst_rte", rev_toggle_en, 0);
        check("mid_rst_gain", gain_factor, 0);
        check("mid_rst_dac_data", dac_data, 0);
        step();
        reset = 1'b0;
        repeat (3) step();
        run_sample(12'h0AB, 12'h0AC, 12'h0AE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fx_chain_ctrl.md
Name: fx_chain_ctrl

Overview:
- Sequences each audio sample through the pedal's effect chain: ADC → distortion clip stage → reverb stage → DAC.
- Owns the user controls: debounces the footswitches and gain buttons, holds gain_factor, and issues toggle_en pulses to the effect stages.
- Applies toggles only between samples, so an effect never changes state while a sample is in flight.

Parameters:
- DEBOUNCE_CYCLES, 50000: cycles a synchronized input must stay stable before its debounced level updates.
- DB_W, 16: debounce counter width; must satisfy 2^DB_W > DEBOUNCE_CYCLES.
- MAX_GAIN, 4: upper saturation value of gain_factor.
- TIMEOUT, 15: maximum wait cycles for a stage response before abort.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sample_tick  in  1  one-cycle strobe: adc_data is valid
- adc_data  in  12  input sample
- sw_dist  in  1  raw distortion footswitch (asynchronous, bouncy)
- sw_rev  in  1  raw reverb footswitch
- btn_gain_up  in  1  raw gain-increment button
- btn_gain_dn  in  1  raw gain-decrement button
- err_clr  in  1  clears the sticky error flags
- dist_A  out  12  sample to the clip stage
- dist_valid_in  out  1  one-cycle strobe with dist_A
- dist_S  in  12  clip stage result
- dist_valid_out  in  1  clip stage result valid
- dist_toggle_en  out  1  one-cycle toggle pulse to the clip stage
- gain_factor  out  12  clip stage gain exponent, range 0..MAX_GAIN
- rev_in  out  12  sample to the reverb stage
- rev_update  out  1  one-cycle strobe with rev_in
- rev_out  in  12  reverb result
- rev_valid_out  in  1  reverb result valid
- rev_toggle_en  out  1  level, 1 while reverb is enabled; reverb accumulates only when update && toggle_en
- dac_data  out  12  output sample
- dac_valid  out  1  one-cycle strobe with dac_data
- busy  out  1  high when the FSM is not in IDLE
- overrun  out  1  sticky: sample_tick arrived while busy
- timeout_err  out  1  sticky: a stage failed to respond within TIMEOUT cycles

Behaviour:
- Reset: all outputs 0; FSM in IDLE; gain_factor 0; rev_toggle_en 0; debounced levels 0; pending flags 0.
- Input conditioning:
  - Each raw input passes through a 2-FF synchronizer.
  - Debounce: the counter resets on any change of the synchronized value; when it reaches DEBOUNCE_CYCLES, the debounced level takes the synchronized value.
  - A rising edge of a debounced level sets a pending flag: dist_pend, rev_pend, up_pend or dn_pend.
- Control application: in IDLE, on a cycle with no sample_tick, all pending flags apply together and clear.
  - dist_pend: dist_toggle_en pulses for 1 cycle.
  - rev_pend: rev_toggle_en inverts.
  - up_pend and dn_pend both set: gain_factor unchanged.
  - up_pend only: gain_factor increments, saturating at MAX_GAIN.
  - dn_pend only: gain_factor decrements, saturating at 0.
- While busy, pending flags hold. A repeated edge while a flag is already pending is absorbed (no double toggle).
- FSM states: IDLE, DIST, REV, OUT.
  - IDLE → DIST on sample_tick; that same cycle: dist_A ← adc_data, dist_valid_in = 1 for 1 cycle.
  - DIST: wait for dist_valid_out; on it: rev_in ← dist_S, rev_update = 1 for 1 cycle; → REV.
  - REV: wait for rev_valid_out; on it: dac_data ← rev_out; → OUT.
  - OUT: dac_valid = 1 for 1 cycle; → IDLE.
- Latency with single-cycle stages: tick at cycle T → dist_valid_in at T+1 → rev_update at T+3 → dac_valid at T+5. Strobes are registered outputs.
- Timeout: a wait counter resets on entry to DIST and to REV. If it reaches TIMEOUT without the expected valid: set timeout_err, go to IDLE, drop the sample (no dac_valid); dac_data keeps its previous value.
- Overrun: sample_tick while busy sets overrun; that sample is ignored and the in-flight sample continues unaffected.
- err_clr clears overrun and timeout_err next cycle. If err_clr and a new error event occur in the same cycle, the set wins.
- Stray dist_valid_out or rev_valid_out received in IDLE or OUT is ignored.
- Reset asserted mid-operation: all state returns to reset values immediately; the in-flight sample is discarded.

Test Plan (bench uses DEBOUNCE_CYCLES=4, TIMEOUT=6; stages modelled as 1-cycle echo, dist_S = dist_A + 1, rev_out = rev_in + 2):
- Nominal: sample_tick with adc_data=0x100 at cycle T → dist_valid_in at T+1, rev_update with rev_in=0x101 at T+3, dac_valid with dac_data=0x103 at T+5; busy low at T+6.
- Bounce: sw_dist toggles 0/1 every 2 cycles for 20 cycles, then held 1 → exactly one dist_toggle_en pulse, issued ≥ 6 cycles after the final change and only while idle.
- Gain saturation: 6 debounced up presses → gain_factor 0,1,2,3,4,4,4; then 5 down presses → 0; simultaneous up+dn pending → unchanged.
- Deferred toggle: sw_rev press debounces while FSM is in REV → rev_toggle_en unchanged until the first idle cycle after dac_valid, then inverts.
- Overrun/timeout: second sample_tick at T+2 → overrun=1, only one dac_valid; rev model silent → timeout_err=1 six cycles after REV entry, busy=0, no dac_valid; err_clr → both flags 0.
- Reset mid-flight: assert reset during DIST → all outputs 0, rev_toggle_en=0, gain_factor=0; the next tick after release is processed normally.
